// File: rtl/result_display.sv
// rtl/result_display.sv - 16-bit binary to 5-digit BCD (serial double-dabble) with multiplexed 7-segment scan.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks digits above the most significant nonzero digit.
module result_display #(
    parameter int SCAN_DIV = 1000
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        LOAD,
    input  logic [15:0] DATA,
    output logic        BUSY,
    output logic        VALID,
    output logic [19:0] BCD,
    output logic [6:0]  SEG,
    output logic [4:0]  AN
);

    localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONVERT,
        S_SHOW
    } state_t;

    state_t       r_state, w_state_nxt;
    logic [15:0]  r_shift, w_shift_nxt;
    logic [19:0]  r_scratch, w_scratch_nxt;
    logic [4:0]   r_cnt, w_cnt_nxt;
    logic [19:0]  r_bcd, w_bcd_nxt;
    logic         r_valid, w_valid_nxt;
    logic         r_busy, w_busy_nxt;
    logic [DIV_W-1:0] r_div, w_div_nxt;
    logic [2:0]   r_idx, w_idx_nxt;
    logic [6:0]   r_seg, w_seg_nxt;
    logic [4:0]   r_an, w_an_nxt;

    logic [19:0]  w_adj;
    logic [19:0]  w_scratch_shifted;
    logic         w_div_term;
    logic [3:0]   w_nib;
    logic         w_show;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    // Add-3 correction on every nibble at once, ahead of the shift.
    always_comb begin
        w_adj = r_scratch;
        for (int i = 0; i < 5; i++) begin
            if (r_scratch[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_scratch[4*i +: 4] + 4'd3;
            end
        end
    end

    assign w_scratch_shifted = {w_adj[18:0], r_shift[15]};

    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_scratch_nxt = r_scratch;
        w_cnt_nxt     = r_cnt;
        w_bcd_nxt     = r_bcd;
        w_valid_nxt   = r_valid;
        w_busy_nxt    = r_busy;
        case (r_state)
            S_IDLE, S_SHOW: begin
                if (LOAD) begin
                    w_shift_nxt   = DATA;
                    w_scratch_nxt = 20'd0;
                    w_cnt_nxt     = 5'd16;
                    w_busy_nxt    = 1'b1;
                    w_state_nxt   = S_CONVERT;
                end
            end
            S_CONVERT: begin
                w_scratch_nxt = w_scratch_shifted;
                w_shift_nxt   = {r_shift[14:0], 1'b0};
                w_cnt_nxt     = r_cnt - 5'd1;
                if (r_cnt == 5'd1) begin
                    w_bcd_nxt   = w_scratch_shifted;
                    w_valid_nxt = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = S_SHOW;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    assign w_div_term = (r_div == DIV_W'(SCAN_DIV - 1));
    assign w_div_nxt  = w_div_term ? '0 : r_div + DIV_W'(1);

    always_comb begin
        w_idx_nxt = r_idx;
        if (w_div_term) begin
            w_idx_nxt = (r_idx == 3'd4) ? 3'd0 : r_idx + 3'd1;
        end
    end

    // Drive segments from next-cycle state so SEG/AN always match idx, BCD and VALID.
    always_comb begin
        case (w_idx_nxt)
            3'd0:    w_nib = w_bcd_nxt[3:0];
            3'd1:    w_nib = w_bcd_nxt[7:4];
            3'd2:    w_nib = w_bcd_nxt[11:8];
            3'd3:    w_nib = w_bcd_nxt[15:12];
            default: w_nib = w_bcd_nxt[19:16];
        endcase
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [4:0] w_nz;
    logic [4:0] w_keep;
    always_comb begin
        w_nz = 5'd0;
        for (int i = 0; i < 5; i++) begin
            w_nz[i] = (w_bcd_nxt[4*i +: 4] != 4'd0);
        end
    end
    assign w_keep = {w_nz[4], |w_nz[4:3], |w_nz[4:2], |w_nz[4:1], 1'b1};
    assign w_show = w_keep[w_idx_nxt];
`else
    assign w_show = 1'b1;
`endif

    always_comb begin
        w_an_nxt  = 5'b11111;
        w_seg_nxt = 7'h7F;
        if (w_valid_nxt && w_show) begin
            w_an_nxt  = ~(5'b00001 << w_idx_nxt);
            w_seg_nxt = seg_decode(w_nib);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state   <= S_IDLE;
            r_shift   <= 16'd0;
            r_scratch <= 20'd0;
            r_cnt     <= 5'd0;
            r_bcd     <= 20'd0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_div     <= '0;
            r_idx     <= 3'd0;
            r_seg     <= 7'h7F;
            r_an      <= 5'b11111;
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_scratch <= w_scratch_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bcd     <= w_bcd_nxt;
            r_valid   <= w_valid_nxt;
            r_busy    <= w_busy_nxt;
            r_div     <= w_div_nxt;
            r_idx     <= w_idx_nxt;
            r_seg     <= w_seg_nxt;
            r_an      <= w_an_nxt;
        end
    end

    assign BUSY  = r_busy;
    assign VALID = r_valid;
    assign BCD   = r_bcd;
    assign SEG   = r_seg;
    assign AN    = r_an;

endmodule

// File: doc/result_display.md
# result_display

Output-side counterpart to the vector input path: it consumes the 16-bit dot-product result and its completion pulse from the compute stage and presents the value to the user. Binary is converted to five BCD digits by a sequential double-dabble engine, one bit per clock. The digits are then time-multiplexed onto a common 7-segment display. It sits between the compute block's `result`/`DONE` outputs and the board display pins.

## Interface
- `SCAN_DIV`, default 1000: clocks per digit dwell in the display scan; legal range is 2 and above.
- `CLK` in 1: system clock; all logic is rising-edge.
- `RST_N` in 1: asynchronous, active-low reset.
- `LOAD` in 1: single-cycle pulse, driven from the compute block's `DONE`; starts a conversion of `DATA`.
- `DATA` in 16: unsigned binary value; sampled only on the edge where `LOAD` is high.
- `BUSY` out 1: high while a conversion is in progress.
- `VALID` out 1: high once at least one conversion has completed since reset.
- `BCD` out 20: packed BCD digits; `[3:0]` is the ones digit and `[19:16]` is the ten-thousands digit.
- `SEG` out 7: active-low segment drive, with bit order `[6:0]` = g,f,e,d,c,b,a.
- `AN` out 5: active-low digit enables; at most one bit is low at a time; `AN[0]` selects the ones digit.

## Operation
- FSM states:
  - IDLE (entered from reset).
  - CONVERT.
  - SHOW.
- IDLE or SHOW, `LOAD`=1:
  - Capture `DATA` into the shift register.
  - Clear the 20-bit scratch BCD register.
  - Set the iteration counter to 16.
  - Enter CONVERT with `BUSY`=1.
- CONVERT, each cycle:
  - For every scratch nibble ≥5, add 3 to that nibble; all five nibbles are adjusted in parallel.
  - Shift {scratch, shift register} left by 1.
  - Decrement the counter.
- On the cycle where the counter reaches 0:
  - Copy the shifted scratch value into the `BCD` output register.
  - Set `VALID`=1 and `BUSY`=0.
  - Enter SHOW.
- `LOAD` while in CONVERT is ignored: the value is dropped and the conversion in progress is unaffected.
- `BCD` changes only at the end of a conversion, so the display keeps showing the previous value during CONVERT (no flicker or partial values).
- Arithmetic: 16-bit input, maximum 65535, always fits in 5 digits; no overflow path exists.
- Scan logic:
  - Divider counts 0..`SCAN_DIV`-1.
  - On the terminal count, the digit index advances 0→1→2→3→4→0.
  - `AN` is low only at the current index.
  - `SEG` shows the decoded nibble `BCD[4*idx+:4]`.
- When `VALID`=0: `AN`=5'b11111 and `SEG`=7'h7F. The divider and index still run.
- Decoder patterns, written as `SEG[6:0]`:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001.
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Non-decimal codes decode to 7'h7F (blank).

## Timing
- Reset values: `BUSY`=0, `VALID`=0, `BCD`=0, `AN`=5'b11111, `SEG`=7'h7F, divider=0, index=0, state IDLE.
- Conversion latency:
  - `LOAD` is sampled at edge k; `BUSY` is high after edge k.
  - Conversion iterations occur at edges k+1..k+16.
  - `BCD`/`VALID` are updated and `BUSY` falls at edge k+16.
  - This gives exactly 16 cycles of `BUSY`.
- `LOAD` at edge k+16 (the completion edge) is ignored; `LOAD` at edge k+17 or later starts a new conversion.
- `SEG`/`AN` are registered and change on the same edge as the index advance.
- Each digit dwells for exactly `SCAN_DIV` cycles.
- Asserting `RST_N` mid-conversion or mid-scan immediately forces all reset values; a partially converted result is discarded.

## Configuration
- `LEADING_ZERO_BLANK_EN` defined:
  - Digits above the most significant nonzero digit are blanked (`SEG`=7'h7F, `AN` bit held high during that slot).
  - Digit 0 is always shown, so value 0 displays a single "0".
- `LEADING_ZERO_BLANK_EN` undefined: all five digits are always shown, including leading zeros.
- The `BCD` output is identical in both builds.

## Test plan
- Reset: hold `RST_N`=0, then release → `BUSY`=0, `VALID`=0, `BCD`=20'h00000, `AN`=5'b11111, `SEG`=7'h7F.
- `LOAD` with `DATA`=16'd12345 → `BUSY` high for exactly 16 cycles, then `BCD`=20'h12345 and `VALID`=1 on the same edge `BUSY` falls.
- `DATA`=16'd65535 → `BCD`=20'h65535. `DATA`=0 → `BCD`=20'h00000 with `VALID`=1.
- `LOAD` 12345, then `LOAD` 999 five cycles later → `BCD`=20'h12345, with the second load ignored. `RST_N` pulsed at cycle 8 of a conversion → all reset values; no `BCD` update afterwards.
- `SCAN_DIV`=4 after 12345:
  - `AN` sequence 11110, 11101, 11011, 10111, 01111, each lasting 4 cycles, then wraps.
  - `SEG`=0010010 while `AN`=11110.
- `DATA`=42, `SCAN_DIV`=4:
  - With `LEADING_ZERO_BLANK_EN`: slots 2-4 give `SEG`=7'h7F and `AN`=11111; slot 1 shows 0011001.
  - Without the macro: slots 2-4 show 1000000.
